// File: rtl/dm_pkg.sv
// Shared constants for the sized data memory: access-size codes,
// FSM states and the poison word returned by trapped loads.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] DM_POISON = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for dm_sized: write mask, lane-replicated store
// data, extended load data and misalignment flag.
// Ports: off_i (addr[1:0]), size_i, sext_i, din_i, rword_i (raw word);
//        wmask_o, wdata_o, rdata_o, misalign_o.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] din_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic       is_b;
    logic       is_h;
    logic [7:0] rb;
    logic [15:0] rh;

    assign is_b = (size_i == SZ_BYTE);
    assign is_h = (size_i == SZ_HALF);
    assign rb   = rword_i[{off_i, 3'b000} +: 8];
    assign rh   = off_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Store data is replicated across lanes so the mask alone picks
    // which copy lands; reserved size 2'b11 falls through to word.
    always_comb begin
        wmask_o    = 4'b1111;
        wdata_o    = din_i;
        rdata_o    = rword_i;
        misalign_o = |off_i;
        unique case (1'b1)
            is_b: begin
                wmask_o    = 4'b0001 << off_i;
                wdata_o    = {4{din_i[7:0]}};
                rdata_o    = {{24{sext_i & rb[7]}}, rb};
                misalign_o = 1'b0;
            end
            is_h: begin
                wmask_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{din_i[15:0]}};
                rdata_o    = {{16{sext_i & rh[15]}}, rh};
                misalign_o = off_i[0];
            end
            default: begin
                wmask_o    = 4'b1111;
                wdata_o    = din_i;
                rdata_o    = rword_i;
                misalign_o = |off_i;
            end
        endcase
    end

endmodule

// File: rtl/dm_sized.sv
// MEM-stage data memory with byte/half/word access and a one-word-per-
// cycle clear sweep after reset (busy high until done).
// Ports: clk, rst (sync, active high), addr, din, DMWr, size, sext;
//        dout, busy, misalign; err_o only with DM_MISALIGN_TRAP_EN.
// DM_MISALIGN_TRAP_EN: suppress misaligned stores, poison misaligned
// loads and raise the sticky err_o flag.
module dm_sized
    import dm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    input  logic          DMWr,
    input  logic [1:0]    size,
    input  logic          sext,
    output logic [31:0]   dout,
    output logic          busy,
    output logic          misalign
`ifdef DM_MISALIGN_TRAP_EN
    ,
    output logic          err_o
`endif
);

    localparam int WW = AW - 2;

    logic [31:0]   mem_q [DEPTH];
    dm_state_e     state_q;
    logic [WW-1:0] ptr_q;
    logic          busy_q;

    logic [WW-1:0] widx;
    logic [31:0]   rword;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          mis;
    logic          we;

    assign widx  = addr[AW-1:2];
    assign rword = mem_q[widx];

    dm_lane_align u_align (
        .off_i      (addr[1:0]),
        .size_i     (size),
        .sext_i     (sext),
        .din_i      (din),
        .rword_i    (rword),
        .wmask_o    (wmask),
        .wdata_o    (wdata),
        .rdata_o    (rdata),
        .misalign_o (mis)
    );

    assign misalign = mis;
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else if (state_q == ST_CLEAR) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == WW'(DEPTH - 1)) begin
                state_q <= ST_READY;
                busy_q  <= 1'b0;
            end
        end
    end

`ifdef DM_MISALIGN_TRAP_EN
    logic err_q;

    assign we   = DMWr && (state_q == ST_READY) && !mis;
    assign dout = busy_q ? 32'h0 : (mis ? DM_POISON : rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (mis && (DMWr || state_q == ST_READY)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign we   = DMWr && (state_q == ST_READY);
    assign dout = busy_q ? 32'h0 : rdata;
`endif

    // The array has no reset of its own; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (wmask[i]) begin
                        mem_q[widx][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_sized.sv
// Self-checking bench for dm_sized against a byte-array model.
// Works with and without DM_MISALIGN_TRAP_EN.
module tb_dm_sized;

    localparam int DEPTH = 1024;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic          DMWr;
    logic [1:0]    size;
    logic          sext;
    logic [31:0]   dout;
    logic          busy;
    logic          misalign;
`ifdef DM_MISALIGN_TRAP_EN
    logic          err_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_b [DEPTH*4];
    logic       err_m;

    always #5 clk = ~clk;

    dm_sized #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .din      (din),
        .DMWr     (DMWr),
        .size     (size),
        .sext     (sext),
        .dout     (dout),
        .busy     (busy),
        .misalign (misalign)
`ifdef DM_MISALIGN_TRAP_EN
        ,
        .err_o    (err_o)
`endif
    );

    function automatic logic m_mis(input int a, input logic [1:0] sz);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] m_load(input int a, input logic [1:0] sz,
                                           input logic sx);
        int          b;
        logic [7:0]  v8;
        logic [15:0] v16;
`ifdef DM_MISALIGN_TRAP_EN
        if (m_mis(a, sz)) return 32'hDEAD_BEEF;
`endif
        if (sz == 2'b00) begin
            v8 = mem_b[a];
            return sx ? {{24{v8[7]}}, v8} : {24'h0, v8};
        end
        if (sz == 2'b01) begin
            b   = a - (a % 2);
            v16 = {mem_b[b+1], mem_b[b]};
            return sx ? {{16{v16[15]}}, v16} : {16'h0, v16};
        end
        b = a - (a % 4);
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    function automatic void m_store(input int a, input logic [31:0] d,
                                    input logic [1:0] sz);
        int b;
`ifdef DM_MISALIGN_TRAP_EN
        if (m_mis(a, sz)) return;
`endif
        if (sz == 2'b00) begin
            mem_b[a] = d[7:0];
        end else if (sz == 2'b01) begin
            b = a - (a % 2);
            mem_b[b]   = d[7:0];
            mem_b[b+1] = d[15:8];
        end else begin
            b = a - (a % 4);
            for (int k = 0; k < 4; k++) mem_b[b+k] = d[k*8 +: 8];
        end
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < DEPTH*4; k++) mem_b[k] = 8'h00;
    endfunction

    task automatic st(input int a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        addr = AW'(a); din = d; size = sz; sext = 1'b0; DMWr = 1'b1;
        m_store(a, d, sz);
        @(posedge clk);
        #1 DMWr = 1'b0;
    endtask

    task automatic ld(input int a, input logic [1:0] sz, input logic sx,
                      output logic [31:0] v);
        @(negedge clk);
        addr = AW'(a); size = sz; sext = sx; DMWr = 1'b0;
        #1 v = dout;
    endtask

    // Pulse rst for one cycle and count cycles until busy drops.
    task automatic sweep(output int cyc);
        @(negedge clk);
        rst = 1'b1; DMWr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(posedge clk);
            #1 cyc++;
        end
        m_clear();
        err_m = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        logic [31:0] v;
        st(32'h008, 32'h1234_5678, 2'b10);
        st(32'h3F0, 32'hA5A5_5A5A, 2'b10);
        st(32'hFA0, 32'h0BAD_CAFE, 2'b10);
        @(negedge clk);
        rst = 1'b1; addr = 12'h3F0; size = 2'b10;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (busy !== 1'b1 || dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b dout=%h want busy=1 dout=0", busy, dout);
        end
        cyc = 0;
        while (busy && cyc < 5000) begin
            if (cyc == 5) begin
                checks++;
                if (dout !== 32'h0) begin
                    errors++;
                    $display("FAIL busy_dout got %h want 0", dout);
                end
            end
            if (cyc == 10) begin
                addr = 12'h008; din = 32'hFFFF_FFFF; DMWr = 1'b1;
            end else begin
                DMWr = 1'b0;
            end
            @(posedge clk);
            #1 cyc++;
        end
        DMWr = 1'b0;
        m_clear();
        err_m = 1'b0;
        checks++;
        if (cyc != DEPTH) begin
            errors++;
            $display("FAIL sweep_len got %0d want %0d", cyc, DEPTH);
        end
        for (int w = 0; w < DEPTH; w++) begin
            ld(w * 4, 2'b10, 1'b0, v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL clear_word[%0d] got %h want 0", w, v);
            end
        end
    endtask

    task automatic test_byte();
        logic [31:0] v;
        st(32'h10, 32'h1122_3344, 2'b10);
        st(32'h12, 32'h0000_00AA, 2'b00);
        ld(32'h10, 2'b10, 1'b0, v);
        checks++;
        if (v !== 32'h11AA_3344) begin
            errors++;
            $display("FAIL byte_lw got %h want 11aa3344", v);
        end
        ld(32'h12, 2'b00, 1'b1, v);
        checks++;
        if (v !== 32'hFFFF_FFAA) begin
            errors++;
            $display("FAIL lb_sext got %h want ffffffaa", v);
        end
        ld(32'h12, 2'b00, 1'b0, v);
        checks++;
        if (v !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL lbu got %h want 000000aa", v);
        end
    endtask

    task automatic test_half();
        logic [31:0] v;
        st(32'h22, 32'h0000_8001, 2'b01);
        ld(32'h20, 2'b10, 1'b0, v);
        checks++;
        if (v !== 32'h8001_0000) begin
            errors++;
            $display("FAIL half_lw got %h want 80010000", v);
        end
        ld(32'h22, 2'b01, 1'b1, v);
        checks++;
        if (v !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh_sext got %h want ffff8001", v);
        end
        ld(32'h22, 2'b01, 1'b0, v);
        checks++;
        if (v !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu got %h want 00008001", v);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        addr = 12'h040; din = 32'h5; size = 2'b10; sext = 1'b0; DMWr = 1'b1;
        #1;
        checks++;
        if (dout !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_pre got %h want 0", dout);
        end
        m_store(32'h40, 32'h5, 2'b10);
        @(posedge clk);
        #1 DMWr = 1'b0;
        checks++;
        if (dout !== 32'h5) begin
            errors++;
            $display("FAIL same_cycle_post got %h want 5", dout);
        end
    endtask

    task automatic test_random();
        int          a;
        logic [1:0]  sz;
        logic        sx;
        logic        wr;
        logic [31:0] d;
        logic [31:0] exp;
        for (int n = 0; n < 400; n++) begin
            a  = int'($urandom_range(0, 255));
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            @(negedge clk);
            addr = AW'(a); size = sz; sext = sx; din = d; DMWr = wr;
            #1;
            exp = m_load(a, sz, sx);
            checks++;
            if (dout !== exp || misalign !== m_mis(a, sz)) begin
                errors++;
                $display("FAIL rand_load a=%h sz=%0d sx=%b got %h/%b want %h/%b",
                         a, sz, sx, dout, misalign, exp, m_mis(a, sz));
            end
`ifdef DM_MISALIGN_TRAP_EN
            checks++;
            if (err_o !== err_m) begin
                errors++;
                $display("FAIL rand_err got %b want %b", err_o, err_m);
            end
            if (m_mis(a, sz)) err_m = 1'b1;
`endif
            if (wr) m_store(a, d, sz);
        end
        @(negedge clk);
        DMWr = 1'b0; addr = '0; size = 2'b10;
    endtask

    task automatic test_misalign();
        logic [31:0] v;
        logic [31:0] old;
        old = m_load(32'h30, 2'b10, 1'b0);
        @(negedge clk);
        addr = 12'h031; din = 32'hCAFE_F00D; size = 2'b10; DMWr = 1'b1;
        #1;
        checks++;
        if (misalign !== 1'b1) begin
            errors++;
            $display("FAIL misalign_flag got %b want 1", misalign);
        end
        @(posedge clk);
        #1 DMWr = 1'b0;
        ld(32'h30, 2'b10, 1'b0, v);
`ifdef DM_MISALIGN_TRAP_EN
        checks++;
        if (v !== old) begin
            errors++;
            $display("FAIL trap_nowrite got %h want %h", v, old);
        end
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL trap_err got %b want 1", err_o);
        end
        ld(32'h31, 2'b10, 1'b0, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL trap_poison got %h want deadbeef", v);
        end
`else
        checks++;
        if (v !== 32'hCAFE_F00D || old === 32'hCAFE_F00D && 1'b0) begin
            errors++;
            $display("FAIL misalign_store got %h want cafef00d", v);
        end
        m_store(32'h31, 32'hCAFE_F00D, 2'b10);
`endif
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        logic [31:0] v;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (500) @(posedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy got %b want 1", busy);
        end
        sweep(cyc);
        checks++;
        if (cyc != DEPTH) begin
            errors++;
            $display("FAIL restart_len got %0d want %0d", cyc, DEPTH);
        end
        ld(32'h10, 2'b10, 1'b0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL restart_clear got %h want 0", v);
        end
`ifdef DM_MISALIGN_TRAP_EN
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared got %b want 0", err_o);
        end
`endif
    endtask

    initial begin
        int cyc;
        rst = 1'b1; addr = '0; din = '0; DMWr = 1'b0;
        size = 2'b10; sext = 1'b0; err_m = 1'b0;
        repeat (2) @(posedge clk);
        sweep(cyc);
        checks++;
        if (cyc != DEPTH) begin
            errors++;
            $display("FAIL first_sweep got %0d want %0d", cyc, DEPTH);
        end
        test_reset();
        test_byte();
        test_half();
        test_same_cycle();
        test_random();
        test_misalign();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
